// File: rtl/bnn_acc_ctrl.sv
// rtl/bnn_acc_ctrl.sv - XNOR/popcount sequencer driving the add1/sub1 ALU for BNN dot products
module bnn_acc_ctrl #(
  parameter int N     = 12,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x_bit,
  input  logic             w_bit,
  output logic             alu_op,
  output logic             alu_a_lsb,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_out,
  output logic [N-1:0]     result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam logic alu_op_add1 = 1'b0;
  localparam logic alu_op_sub1 = 1'b1;

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_acc  = 2'd1,
    s_done = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_idle;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    alu_op    = alu_op_add1;
    alu_a_lsb = 1'b0;
    beat      = (state == s_acc) && in_valid;

    // XNOR of the pair picks +1 on match, -1 on mismatch
    if (beat) begin
      alu_a_lsb = 1'b1;
      alu_op    = (x_bit == w_bit) ? alu_op_add1 : alu_op_sub1;
    end

    unique case (state)
      s_idle: begin
        if (start) begin
          acc_nxt   = '0;
          cnt_nxt   = len;
          state_nxt = (len == '0) ? s_done : s_acc;
        end
      end
      s_acc: begin
        if (beat) begin
          acc_nxt = alu_out;
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nxt = s_done;
        end
      end
      s_done: begin
        if (result_ready) state_nxt = s_idle;
      end
      default: state_nxt = s_idle;
    endcase

    // abort overrides any start, beat or result handshake in the same cycle
    if (abort) begin
      state_nxt = s_idle;
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  assign in_ready     = (state == s_acc);
  assign result_valid = (state == s_done);
  assign busy         = (state != s_idle);
  assign alu_b        = acc;
  assign result       = acc;

endmodule

// File: tb/tb_bnn_acc_ctrl.sv
// tb/tb_bnn_acc_ctrl.sv - directed self-checking bench for bnn_acc_ctrl with a behavioural ALU
module tb_bnn_acc_ctrl;

  localparam int N     = 12;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             x_bit;
  logic             w_bit;
  logic             alu_op;
  logic             alu_a_lsb;
  logic [N-1:0]     alu_b;
  logic [N-1:0]     alu_out;
  logic [N-1:0]     result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // add1 = 0, sub1 = 1; increment is zero-extended from alu_a_lsb
  assign alu_out = (alu_op == 1'b0) ? alu_b + N'(alu_a_lsb) : alu_b - N'(alu_a_lsb);

  bnn_acc_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .x_bit(x_bit), .w_bit(w_bit),
    .alu_op(alu_op), .alu_a_lsb(alu_a_lsb), .alu_b(alu_b), .alu_out(alu_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic x, input logic w, input logic [N-1:0] exp_acc);
    in_valid = 1'b1;
    x_bit    = x;
    w_bit    = w;
    #1;
    chk("beat_in_ready", in_ready, 1);
    chk("beat_alu_op", alu_op, (x == w) ? 0 : 1);
    step();
    chk("beat_acc", alu_b, exp_acc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    in_valid = 1'b0; x_bit = 1'b0; w_bit = 1'b0; result_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_a_lsb", alu_a_lsb, 0);
    chk("rst_alu_op", alu_op, 0);
    rst = 1'b0;
    step();

    // all-match, continuous valid, len=4
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    chk("m4_busy", busy, 1);
    beat(1'b1, 1'b1, 12'd1);
    beat(1'b0, 1'b0, 12'd2);
    beat(1'b1, 1'b1, 12'd3);
    chk("m4_no_early_valid", result_valid, 0);
    beat(1'b0, 1'b0, 12'd4);
    in_valid = 1'b0;
    chk("m4_valid", result_valid, 1);
    chk("m4_result", result, 12'd4);
    chk("m4_in_ready_done", in_ready, 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("m4_idle", busy, 0);
    chk("m4_valid_drop", result_valid, 0);

    // mixed pairs with a 2-cycle stall between beats 2 and 3
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    beat(1'b1, 1'b0, 12'hFFF);
    beat(1'b0, 1'b1, 12'hFFE);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_a_lsb", alu_a_lsb, 0);
      chk("stall_in_ready", in_ready, 1);
      step();
      chk("stall_acc_hold", alu_b, 12'hFFE);
    end
    beat(1'b1, 1'b1, 12'hFFF);
    beat(1'b0, 1'b1, 12'hFFE);
    beat(1'b1, 1'b0, 12'hFFD);
    in_valid = 1'b0;
    chk("mix_valid", result_valid, 1);
    chk("mix_result", result, 12'hFFD);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("mix_idle", busy, 0);

    // zero length with back-pressure; start during the handshake is dropped
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("z_valid_hold", result_valid, 1);
      chk("z_result", result, 0);
      chk("z_in_ready", in_ready, 0);
      step();
    end
    result_ready = 1'b1; start = 1'b1; len = 8'd3;
    step();
    result_ready = 1'b0; start = 1'b0;
    chk("z_idle", busy, 0);
    chk("z_valid_drop", result_valid, 0);
    step();
    chk("z_start_ignored", busy, 0);

    // maximum length, all mismatch; a start mid-job must not resample len
    start = 1'b1; len = 8'd255;
    step();
    start = 1'b0;
    in_valid = 1'b1; x_bit = 1'b1; w_bit = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (i == 100) begin
        start = 1'b1; len = 8'd7;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    chk("max_valid", result_valid, 1);
    chk("max_result", result, 12'hF01);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("max_idle", busy, 0);

    // abort colliding with a beat at cnt=3 and a start
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    beat(1'b1, 1'b1, 12'd1);
    beat(1'b1, 1'b1, 12'd2);
    in_valid = 1'b1; abort = 1'b1; start = 1'b1; len = 8'd9;
    step();
    in_valid = 1'b0; abort = 1'b0; start = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_no_valid", result_valid, 0);
    chk("ab_acc_zero", alu_b, 0);
    step();
    chk("ab_start_ignored", busy, 0);
    chk("ab_no_valid2", result_valid, 0);
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    beat(1'b1, 1'b1, 12'd1);
    beat(1'b1, 1'b1, 12'd2);
    in_valid = 1'b0;
    chk("ab_next_valid", result_valid, 1);
    chk("ab_next_result", result, 12'd2);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // asynchronous reset mid-job at cnt=5
    start = 1'b1; len = 8'd8;
    step();
    start = 1'b0;
    beat(1'b1, 1'b1, 12'd1);
    beat(1'b1, 1'b1, 12'd2);
    beat(1'b1, 1'b1, 12'd3);
    in_valid = 1'b1; x_bit = 1'b1; w_bit = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_acc", alu_b, 0);
    chk("arst_result", result, 0);
    chk("arst_result_valid", result_valid, 0);
    chk("arst_alu_a_lsb", alu_a_lsb, 0);
    chk("arst_alu_op", alu_op, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("arst_stays_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
